fp_normalize_round: RTL and testbench

Post-add normalisation and rounding stage for the single-precision floating-point adder. Sits directly downstream of the align/add datapath, which supplies a sign, a biased exponent and an unnormalised significand sum with guard/round/sticky bits. The block renormalises iteratively, one bit per cycle, then rounds to nearest-even and packs the IEEE-754 result. It handles overflow to infinity and flushes underflow to zero. Both sides use valid/ready handshakes.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_rounder.sv | 43 ++++
 rtl/fp_normalize_round.sv | 161 ++++++++++++++++
 tb/tb_fp_normalize_round.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, derived widths, the control state enum and the
// round-to-nearest-even decision used by the normalise/round stage.
package fp_pkg;

  localparam int FRACTION = 23;
  localparam int EXPONENT = 8;
  localparam int BIAS     = 127;

  // {carry, hidden, fraction, G, R, S}
  localparam int MANT_W   = FRACTION + 5;
  // {sign, exponent, fraction}
  localparam int RESULT_W = 1 + EXPONENT + FRACTION;
  // Internal exponent carries two extra bits so that increments past the
  // all-ones field value and decrements are representable as signed values.
  localparam int EXP_W    = EXPONENT + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Round half to even: bump when above half, or exactly half with an odd LSB.
  function automatic logic rne_up(input logic lsb, input logic g,
                                  input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

endpackage

// File: rtl/fp_rounder.sv
// Combinational round-to-nearest-even, post-round carry handling, overflow
// detection and inexact flag for an already normalised significand.
module fp_rounder
  import fp_pkg::*;
(
  input  logic                    sign_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic [FRACTION:0]       sig_i,     // {hidden, fraction}
  input  logic [2:0]              grs_i,     // {G, R, S}
  output logic [RESULT_W-1:0]     result_o,
  output logic                    overflow_o,
  output logic                    inexact_o
);

  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'((1 << EXPONENT) - 1);

  logic                    up_s;
  logic                    carry_s;
  logic [FRACTION-1:0]     frac_s;
  logic signed [EXP_W-1:0] exp_r_s;

  // Increment decision, fraction increment and exponent adjust on carry-out.
  always_comb begin
    up_s    = rne_up(sig_i[0], grs_i[2], grs_i[1], grs_i[0]);
    // The increment only ripples out of {hidden, fraction} when every bit is
    // set; the fraction then wraps to zero on its own.
    carry_s = (&sig_i) & up_s;
    frac_s  = sig_i[FRACTION-1:0] + {{(FRACTION-1){1'b0}}, up_s};
    exp_r_s = exp_i + $signed({{(EXP_W-1){1'b0}}, carry_s});
  end

  // Overflow check, inexact flag and packing of the final word.
  always_comb begin
    overflow_o = (exp_r_s >= EXP_MAX);
    inexact_o  = (|grs_i) | overflow_o;
    if (overflow_o) begin
      result_o = {sign_i, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else begin
      result_o = {sign_i, exp_r_s[EXPONENT-1:0], frac_s};
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalisation and rounding stage: iterative one-bit-per-cycle
// renormalisation, round-to-nearest-even, overflow to infinity and flush of
// underflow to zero. One item in flight, valid/ready on both sides.
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXPONENT-1:0] in_exp,
  input  logic [MANT_W-1:0]   in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result,
  output logic                out_overflow,
  output logic                out_underflow,
  output logic                out_inexact
);

  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_e                  state_q,  state_d;
  logic                    sign_q,   sign_d;
  logic signed [EXP_W-1:0] exp_q,    exp_d;
  logic [MANT_W-1:0]       mant_q,   mant_d;
  logic [RESULT_W-1:0]     result_q, result_d;
  logic                    ovf_q,    ovf_d;
  logic                    unf_q,    unf_d;
  logic                    inx_q,    inx_d;
  logic                    valid_q;
  logic                    ready_q;

  logic [RESULT_W-1:0]     rnd_result_s;
  logic                    rnd_overflow_s;
  logic                    rnd_inexact_s;

  fp_rounder u_rounder (
    .sign_i     (sign_q),
    .exp_i      (exp_q),
    .sig_i      (mant_q[MANT_W-2:3]),
    .grs_i      (mant_q[2:0]),
    .result_o   (rnd_result_s),
    .overflow_o (rnd_overflow_s),
    .inexact_o  (rnd_inexact_s)
  );

  // Next-state and datapath updates for the accept/normalise/round/hold flow.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {2'b00, in_exp};
          mant_d = in_mant;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = 1'b0;
          if (in_mant == {MANT_W{1'b0}}) begin
            // Exact zero sum is always reported as +0.
            result_d = {RESULT_W{1'b0}};
            state_d  = ST_DONE;
          end else if (&in_exp) begin
            // Inf/NaN encodings pass straight through unrounded.
            result_d = {in_sign, in_exp, in_mant[MANT_W-3:3]};
            state_d  = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_NORM: begin
        if (mant_q[MANT_W-1]) begin
          // Carry out of the add: one right shift, dropped bit folds into S.
          mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ST_ROUND;
        end else if (mant_q[MANT_W-2]) begin
          state_d = ST_ROUND;
        end else if (exp_q <= EXP_ONE) begin
          // No room left to shift: flush to signed zero.
          result_d = {sign_q, {(RESULT_W-1){1'b0}}};
          unf_d    = 1'b1;
          inx_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          mant_d  = {mant_q[MANT_W-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
          state_d = ST_NORM;
        end
      end

      ST_ROUND: begin
        result_d = rnd_result_s;
        ovf_d    = rnd_overflow_s;
        inx_d    = rnd_inexact_s;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= {EXP_W{1'b0}};
      mant_q   <= {MANT_W{1'b0}};
      result_q <= {RESULT_W{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
      valid_q  <= (state_d == ST_DONE);
      ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written backpressure and mid-operation reset sequences.
module tb_fp_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp_normalize_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  function automatic logic [27:0] mk(input logic c, input logic h, input logic [22:0] f,
                                     input logic g, input logic r, input logic s);
    return {c, h, f, g, r, s};
  endfunction

  // Reference: value-level normalisation followed by round-half-even on the
  // three discarded bits. Latency counts edges after the accepting edge;
  // zero and pass-through results are already registered by the accepting edge.
  function automatic void ref_model(input logic s, input logic [7:0] ein, input logic [27:0] mant,
                                    output logic [31:0] res, output logic ovf, output logic unf,
                                    output logic inx, output int lat);
    longint mv;
    longint keep;
    longint rem;
    int     e;
    int     p;
    int     nl;
    ovf = 1'b0; unf = 1'b0; inx = 1'b0;
    mv  = longint'(mant);
    e   = int'(ein);
    if (mant == 28'd0) begin
      res = 32'd0; lat = 0; return;
    end
    if (ein == 8'hFF) begin
      res = {s, 8'hFF, mant[25:3]}; lat = 0; return;
    end
    p = -1;
    for (int i = 0; i < 28; i++) if (mant[i]) p = i;
    if (p == 27) begin
      mv  = (mv >> 1) | (mv & 64'd1);
      e   = e + 1;
      lat = 2;
    end else begin
      nl = 26 - p;
      if (nl > 0 && (e - nl) < 1) begin
        res = {s, 31'd0}; unf = 1'b1; inx = 1'b1;
        lat = ((e > 1) ? (e - 1) : 0) + 1;
        return;
      end
      mv  = mv << nl;
      e   = e - nl;
      lat = 2 + nl;
    end
    keep = mv >> 3;
    rem  = mv & 64'd7;
    inx  = (rem != 0);
    if (rem > 4 || (rem == 4 && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'd0}; ovf = 1'b1; inx = 1'b1;
    end else begin
      res = {s, e[7:0], keep[22:0]};
    end
  endfunction

  // Present one operand in IDLE and wait (bounded) for the result.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                        output logic [31:0] res, output logic ovf, output logic unf,
                        output logic inx, output int lat);
    @(negedge clk);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    ovf = out_overflow;
    unf = out_underflow;
    inx = out_inexact;
  endtask

  // Consume the held result and confirm the handshake returns to IDLE.
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop_after_consume", {31'd0, out_valid}, 32'd0);
    check("ready_rise_after_consume", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_op(input string tag, input logic [31:0] res, input logic ovf,
                          input logic unf, input logic inx, input int lat,
                          input logic [31:0] e_res, input logic e_ovf, input logic e_unf,
                          input logic e_inx, input int e_lat);
    check({tag, "_result"},    res, e_res);
    check({tag, "_overflow"},  {31'd0, ovf}, {31'd0, e_ovf});
    check({tag, "_underflow"}, {31'd0, unf}, {31'd0, e_unf});
    check({tag, "_inexact"},   {31'd0, inx}, {31'd0, e_inx});
    check({tag, "_latency"},   32'(lat), 32'(e_lat));
  endtask

  initial begin
    logic [31:0] res;
    logic        ovf, unf, inx;
    int          lat;
    logic [31:0] m_res;
    logic        m_ovf, m_unf, m_inx;
    int          m_lat;
    logic        rs;
    logic [7:0]  re;
    logic [27:0] rm;
    int          sel;
    int          stray;

    // Directed vectors: sign, exp, mant, result, ovf, unf, inx, latency
    vecs[0]  = '{1'b0, 8'd127, mk(1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 1'b0), 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 8'd127, mk(1'b0, 1'b0, 23'h100000, 1'b0, 1'b0, 1'b0), 32'h3E000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b0, 8'd127, mk(1'b0, 1'b1, 23'h000001, 1'b1, 1'b0, 1'b0), 32'h3F800002, 1'b0, 1'b0, 1'b1, 2};
    vecs[3]  = '{1'b0, 8'd127, mk(1'b0, 1'b1, 23'h000002, 1'b1, 1'b0, 1'b0), 32'h3F800002, 1'b0, 1'b0, 1'b1, 2};
    vecs[4]  = '{1'b0, 8'd254, mk(1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b0, 1'b0), 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};
    vecs[5]  = '{1'b1, 8'd127, 28'd0,                                          32'h00000000, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 8'd2,   mk(1'b0, 1'b0, 23'h040000, 1'b0, 1'b0, 1'b0), 32'h80000000, 1'b0, 1'b1, 1'b1, 2};
    vecs[7]  = '{1'b1, 8'd255, mk(1'b0, 1'b1, 23'h123456, 1'b1, 1'b0, 1'b1), 32'hFF923456, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b0, 8'd127, mk(1'b1, 1'b0, 23'h000001, 1'b1, 1'b0, 1'b0), 32'h40000001, 1'b0, 1'b0, 1'b1, 2};
    vecs[9]  = '{1'b0, 8'd254, mk(1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 1'b0), 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};
    vecs[10] = '{1'b0, 8'd127, mk(1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b0), 32'h40000000, 1'b0, 1'b0, 1'b1, 2};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 28'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result",    out_result, 32'd0);
    check("reset_flags",     {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].s, vecs[i].e, vecs[i].m, res, ovf, unf, inx, lat);
      check_op($sformatf("vec%0d", i), res, ovf, unf, inx, lat,
               vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].inx, vecs[i].lat);
      release_out();
    end

    // Backpressure: result and flags hold, in_ready stays low, new input ignored.
    run_op(1'b0, 8'd127, mk(1'b1, 1'b0, 23'h0, 1'b0, 1'b0, 1'b0), res, ovf, unf, inx, lat);
    check("bp_initial_result", res, 32'h40000000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      in_mant  = 28'h0000008;
      in_exp   = 8'd5;
      @(posedge clk); #1;
      check("bp_result_hold", out_result, 32'h40000000);
      check("bp_handshake", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    release_out();

    // Reset while deep in NORM: immediate abort, no stale result afterwards.
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = mk(1'b0, 1'b0, 23'h000001, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_result",    out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("rst_no_stale_valid", 32'(stray), 32'd0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 300; k++) begin
      rs  = 1'($urandom_range(0, 1));
      rm  = 28'($urandom) >> $urandom_range(0, 27);
      sel = $urandom_range(0, 9);
      if (sel == 0)      re = 8'hFF;
      else if (sel == 1) re = 8'($urandom_range(0, 5));
      else if (sel == 2) re = 8'($urandom_range(250, 254));
      else               re = 8'($urandom_range(1, 254));
      ref_model(rs, re, rm, m_res, m_ovf, m_unf, m_inx, m_lat);
      run_op(rs, re, rm, res, ovf, unf, inx, lat);
      check_op($sformatf("rand%0d", k), res, ovf, unf, inx, lat, m_res, m_ovf, m_unf, m_inx, m_lat);
      release_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
